traffic_light_ctrl: RTL and testbench

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/traffic_pkg.sv | 48 ++++
 rtl/tl_tick_gen.sv | 38 +++
 rtl/traffic_light_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared states, lamp patterns and BCD helper for the traffic light controller
//
// Purpose: single home for the FSM state codes, the lamp patterns driven in
// each state and the binary-to-BCD conversion of the seconds countdown.
// Ports: none (package).
//
// LED bit order everywhere: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}.

package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED1  = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED2  = 3'd5,
    NIGHT = 3'd6
  } tl_state_e;

  localparam logic [5:0] LED_NS_G    = 6'b001_100;
  localparam logic [5:0] LED_NS_Y    = 6'b010_100;
  localparam logic [5:0] LED_ALL_RED = 6'b100_100;
  localparam logic [5:0] LED_EW_G    = 6'b100_001;
  localparam logic [5:0] LED_EW_Y    = 6'b100_010;

  // Lamp pattern for a state; in NIGHT both yellows flash together with blink.
  function automatic logic [5:0] led_pattern(input tl_state_e s, input logic blink);
    logic [5:0] p;
    case (s)
      NS_G:    p = LED_NS_G;
      NS_Y:    p = LED_NS_Y;
      EW_G:    p = LED_EW_G;
      EW_Y:    p = LED_EW_Y;
      NIGHT:   p = {1'b0, blink, 1'b0, 1'b0, blink, 1'b0};
      default: p = LED_ALL_RED;
    endcase
    return p;
  endfunction

  // Two-digit BCD {tens, units} of a value in 0..99.
  function automatic logic [7:0] bin2bcd(input logic [6:0] bin);
    int b;
    b = int'(bin);
    return 8'(((b / 10) * 16) + (b % 10));
  endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// rtl/tl_tick_gen.sv - one-second tick prescaler for the traffic light controller
//
// Purpose: counts 0..TICK_DIV-1 and pulses tick for one cycle on the last
// count; clr restarts the count so every phase begins on a fresh second.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   clr    in   restart the count from 0 on the next edge
//   tick   out  one-cycle pulse every TICK_DIV cycles

module tl_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Decoded from the count only, so clr (derived from tick) forms no loop.
  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - two-way junction traffic light sequencer with pedestrian and night modes
//
// Purpose: cycles NS_G -> NS_Y -> RED1 -> EW_G -> EW_Y -> RED2 on a per-second
// countdown, shortens green on a pedestrian request and falls back to a
// flashing-yellow NIGHT mode while night is held.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   ped_req_n  in   raw pedestrian button, active-low, asynchronous
//   night      in   night-mode request level, asynchronous
//   led        out  {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}, registered
//   cnt_bcd    out  remaining seconds {tens, units} in BCD, registered
//   ped_pend   out  pedestrian request latched and not yet served, registered
//   phase      out  current state code, registered

module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int T_GREEN  = 25,
  parameter int T_YELLOW = 5,
  parameter int T_ALLRED = 2,
  parameter int T_PEDMIN = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req_n,
  input  logic       night,
  output logic [5:0] led,
  output logic [7:0] cnt_bcd,
  output logic       ped_pend,
  output logic [2:0] phase
);

  if (TICK_DIV < 2 ||
      T_GREEN  < 1 || T_GREEN  > 99 ||
      T_YELLOW < 1 || T_YELLOW > 99 ||
      T_ALLRED < 1 || T_ALLRED > 99 ||
      T_PEDMIN < 1 || T_PEDMIN > 99 ||
      T_PEDMIN > T_GREEN) begin : g_param_check
    $error("traffic_light_ctrl: timing parameter out of range");
  end

  localparam logic [6:0] CD_GREEN  = 7'(T_GREEN);
  localparam logic [6:0] CD_YELLOW = 7'(T_YELLOW);
  localparam logic [6:0] CD_ALLRED = 7'(T_ALLRED);
  localparam logic [6:0] CD_PEDMIN = 7'(T_PEDMIN);

  // Input synchronisers; ped_prev is the edge-detect stage behind ped_s2.
  logic ped_s1, ped_s2, ped_prev;
  logic night_s1, night_s;
  logic ped_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_s1   <= 1'b1;
      ped_s2   <= 1'b1;
      ped_prev <= 1'b1;
      night_s1 <= 1'b0;
      night_s  <= 1'b0;
    end else begin
      ped_s1   <= ped_req_n;
      ped_s2   <= ped_s1;
      ped_prev <= ped_s2;
      night_s1 <= night;
      night_s  <= night_s1;
    end
  end

  assign ped_evt = ped_prev & ~ped_s2;

  tl_state_e  state_q, state_d;
  logic [6:0] cd_q, cd_d;
  logic       blink_q, blink_d;
  logic       pend_d;
  // Set when a green ended with a request pending: that request is served by
  // the following red. A request latched during yellow survives the red and
  // shortens the next green instead.
  logic       served_q, served_d;
  logic       tick;

  tl_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_d != state_q),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    cd_d     = cd_q;
    blink_d  = blink_q;
    pend_d   = ped_pend;
    served_d = served_q;

    case (state_q)
      NS_G, EW_G: begin
        if (tick && (night_s || cd_q == 7'd1)) begin
          state_d  = (state_q == NS_G) ? NS_Y : EW_Y;
          cd_d     = CD_YELLOW;
          served_d = ped_pend;
        end else if (ped_pend && (cd_q > CD_PEDMIN)) begin
          // Shortening wins over a same-cycle decrement; prescaler keeps running.
          cd_d = CD_PEDMIN;
        end else if (tick) begin
          cd_d = cd_q - 7'd1;
        end
      end

      NS_Y, EW_Y: begin
        if (tick) begin
          if (cd_q == 7'd1) begin
            state_d  = (state_q == NS_Y) ? RED1 : RED2;
            cd_d     = CD_ALLRED;
            served_d = 1'b0;
            if (served_q) begin
              pend_d = 1'b0;
            end
          end else begin
            cd_d = cd_q - 7'd1;
          end
        end
      end

      RED1, RED2: begin
        if (tick) begin
          if (cd_q == 7'd1) begin
            if (night_s) begin
              state_d = NIGHT;
              cd_d    = '0;
              blink_d = 1'b1;
            end else begin
              state_d = (state_q == RED1) ? EW_G : NS_G;
              cd_d    = ped_pend ? CD_PEDMIN : CD_GREEN;
            end
          end else begin
            cd_d = cd_q - 7'd1;
          end
        end
      end

      NIGHT: begin
        if (tick) begin
          if (!night_s) begin
            state_d = RED2;
            cd_d    = CD_ALLRED;
            pend_d  = 1'b0;
          end else begin
            blink_d = ~blink_q;
          end
        end
      end

      default: begin
        state_d = RED2;
        cd_d    = CD_ALLRED;
      end
    endcase

    // A fresh request is never lost to a same-cycle clear.
    if (ped_evt) begin
      pend_d = 1'b1;
    end
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RED2;
      cd_q     <= CD_ALLRED;
      blink_q  <= 1'b0;
      served_q <= 1'b0;
      ped_pend <= 1'b0;
      led      <= LED_ALL_RED;
      cnt_bcd  <= bin2bcd(CD_ALLRED);
      phase    <= 3'd5;
    end else begin
      state_q  <= state_d;
      cd_q     <= cd_d;
      blink_q  <= blink_d;
      served_q <= served_d;
      ped_pend <= pend_d;
      led      <= led_pattern(state_d, blink_d);
      cnt_bcd  <= (state_d == NIGHT) ? 8'h00 : bin2bcd(cd_d);
      phase    <= state_d;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - self-checking bench for traffic_light_ctrl

module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ped_req_n = 1'b1;
  logic       night = 1'b0;
  logic [5:0] led;
  logic [7:0] cnt_bcd;
  logic       ped_pend;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int entry_cyc = 0;
  logic [2:0] mon_ph = 3'd5;
  bit sb_on = 1'b1;

  typedef struct {
    logic [2:0] ph;
    logic [5:0] led;
    logic [7:0] bcd;
    int         dur;
  } exp_t;

  exp_t exp_q[$];

  traffic_light_ctrl #(
    .TICK_DIV(4),
    .T_GREEN (6),
    .T_YELLOW(2),
    .T_ALLRED(1),
    .T_PEDMIN(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ped_req_n(ped_req_n),
    .night    (night),
    .led      (led),
    .cnt_bcd  (cnt_bcd),
    .ped_pend (ped_pend),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // Scoreboard consumer plus the always-on safety properties.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      mon_ph    = 3'd5;
      entry_cyc = cyc_cnt;
    end else begin
      if (phase != 3'd6) begin
        checks++;
        if ((led[4] | led[3]) && (led[1] | led[0])) begin
          errors++;
          $display("FAIL conflict: led=%b with both directions non-red in phase %0d", led, phase);
        end
      end
      if (phase !== mon_ph) begin
        checks++;
        if ((mon_ph == 3'd0 && phase !== 3'd1) || (mon_ph == 3'd3 && phase !== 3'd4)) begin
          errors++;
          $display("FAIL green_exit: phase %0d -> %0d, required a yellow", mon_ph, phase);
        end
        if (sb_on) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: phase changed to %0d, required no change", phase);
          end else begin
            e = exp_q.pop_front();
            if (phase !== e.ph) begin
              errors++;
              $display("FAIL sb_phase: got %0d, required %0d", phase, e.ph);
            end
            checks++;
            if (led !== e.led) begin
              errors++;
              $display("FAIL sb_led: phase %0d got %b, required %b", e.ph, led, e.led);
            end
            checks++;
            if (cnt_bcd !== e.bcd) begin
              errors++;
              $display("FAIL sb_cnt_bcd: phase %0d got %h, required %h", e.ph, cnt_bcd, e.bcd);
            end
            checks++;
            if (cyc_cnt - entry_cyc != e.dur) begin
              errors++;
              $display("FAIL sb_duration: before phase %0d got %0d cycles, required %0d",
                       e.ph, cyc_cnt - entry_cyc, e.dur);
            end
          end
        end
        mon_ph    = phase;
        entry_cyc = cyc_cnt;
      end
    end
  end

  function automatic void push_exp(input logic [2:0] ph, input logic [5:0] l,
                                   input logic [7:0] b, input int d);
    exp_t e;
    e.ph = ph; e.led = l; e.bcd = b; e.dur = d;
    exp_q.push_back(e);
  endfunction

  // Returns at negedge+1 of the edge where the scoreboard shrank to 'left'.
  task automatic wait_drain(input int left, input string what);
    int n = 0;
    while (exp_q.size() > left && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() > left) begin
      errors++;
      $display("FAIL %s_timeout: %0d entries pending, required <= %0d", what, exp_q.size(), left);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (led !== 6'b100_100) begin errors++; $display("FAIL reset_led: got %b, required 100100", led); end
    checks++;
    if (cnt_bcd !== 8'h01) begin errors++; $display("FAIL reset_cnt_bcd: got %h, required 01", cnt_bcd); end
    checks++;
    if (phase !== 3'd5) begin errors++; $display("FAIL reset_phase: got %0d, required 5", phase); end
    checks++;
    if (ped_pend !== 1'b0) begin errors++; $display("FAIL reset_ped_pend: got %b, required 0", ped_pend); end
    rst_n = 1'b1;
  endtask

  task automatic test_normal_cycle();
    push_exp(3'd0, 6'b001_100, 8'h06, 4);
    push_exp(3'd1, 6'b010_100, 8'h02, 24);
    push_exp(3'd2, 6'b100_100, 8'h01, 8);
    push_exp(3'd3, 6'b100_001, 8'h06, 4);
    push_exp(3'd4, 6'b100_010, 8'h02, 24);
    push_exp(3'd5, 6'b100_100, 8'h01, 8);
    push_exp(3'd0, 6'b001_100, 8'h06, 4);
    wait_drain(0, "normal");
  endtask

  // Entered at the start of NS_G with countdown 6.
  task automatic test_ped_green();
    push_exp(3'd1, 6'b010_100, 8'h02, 16);
    push_exp(3'd2, 6'b100_100, 8'h01, 8);
    push_exp(3'd3, 6'b100_001, 8'h06, 4);
    ped_req_n = 1'b0;
    repeat (2) begin @(negedge clk); #1; end
    ped_req_n = 1'b1;
    repeat (2) begin @(negedge clk); #1; end
    checks++;
    if (ped_pend !== 1'b1) begin errors++; $display("FAIL ped_green_pend: got %b, required 1", ped_pend); end
    checks++;
    if (cnt_bcd !== 8'h03) begin errors++; $display("FAIL ped_green_force: got %h, required 03", cnt_bcd); end
    wait_drain(1, "ped_green");
    checks++;
    if (ped_pend !== 1'b0) begin errors++; $display("FAIL ped_green_clear: got %b at RED1, required 0", ped_pend); end
    wait_drain(0, "ped_green");
  endtask

  // Entered at the start of EW_G.
  task automatic test_ped_yellow();
    push_exp(3'd4, 6'b100_010, 8'h02, 24);
    wait_drain(0, "ped_yellow");
    push_exp(3'd5, 6'b100_100, 8'h01, 8);
    push_exp(3'd0, 6'b001_100, 8'h03, 4);
    push_exp(3'd1, 6'b010_100, 8'h02, 12);
    push_exp(3'd2, 6'b100_100, 8'h01, 8);
    push_exp(3'd3, 6'b100_001, 8'h06, 4);
    ped_req_n = 1'b0;
    repeat (2) begin @(negedge clk); #1; end
    ped_req_n = 1'b1;
    wait_drain(4, "ped_yellow");
    checks++;
    if (ped_pend !== 1'b1) begin errors++; $display("FAIL ped_yellow_keep: got %b at RED2, required 1", ped_pend); end
    wait_drain(1, "ped_yellow");
    checks++;
    if (ped_pend !== 1'b0) begin errors++; $display("FAIL ped_yellow_clear: got %b at RED1, required 0", ped_pend); end
    wait_drain(0, "ped_yellow");
  endtask

  // Entered at the start of EW_G.
  task automatic test_night();
    night = 1'b1;
    push_exp(3'd4, 6'b100_010, 8'h02, 4);
    push_exp(3'd5, 6'b100_100, 8'h01, 8);
    push_exp(3'd6, 6'b010_010, 8'h00, 4);
    wait_drain(0, "night");
    repeat (4) begin @(negedge clk); #1; end
    checks++;
    if (led !== 6'b000_000) begin errors++; $display("FAIL night_blink_off: got %b, required 000000", led); end
    repeat (4) begin @(negedge clk); #1; end
    checks++;
    if (led !== 6'b010_010) begin errors++; $display("FAIL night_blink_on: got %b, required 010010", led); end
    checks++;
    if (cnt_bcd !== 8'h00) begin errors++; $display("FAIL night_cnt_bcd: got %h, required 00", cnt_bcd); end
    night = 1'b0;
    push_exp(3'd5, 6'b100_100, 8'h01, 12);
    push_exp(3'd0, 6'b001_100, 8'h06, 4);
    wait_drain(0, "night_exit");
  endtask

  // Entered at the start of NS_G.
  task automatic test_reset_mid();
    push_exp(3'd1, 6'b010_100, 8'h02, 24);
    push_exp(3'd2, 6'b100_100, 8'h01, 8);
    push_exp(3'd3, 6'b100_001, 8'h06, 4);
    wait_drain(0, "reset_mid");
    repeat (5) begin @(negedge clk); #1; end
    sb_on = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (led !== 6'b100_100) begin errors++; $display("FAIL reset_mid_led: got %b, required 100100", led); end
    checks++;
    if (cnt_bcd !== 8'h01) begin errors++; $display("FAIL reset_mid_cnt_bcd: got %h, required 01", cnt_bcd); end
    checks++;
    if (phase !== 3'd5) begin errors++; $display("FAIL reset_mid_phase: got %0d, required 5", phase); end
    @(negedge clk);
    #1;
    sb_on = 1'b1;
    rst_n = 1'b1;
    push_exp(3'd0, 6'b001_100, 8'h06, 4);
    push_exp(3'd1, 6'b010_100, 8'h02, 24);
    wait_drain(0, "reset_mid_restart");
  endtask

  task automatic test_random();
    int n = 0;
    sb_on = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 99) < 3) ped_req_n = ~ped_req_n;
      if ($urandom_range(0, 299) == 0) night = ~night;
    end
    night = 1'b0;
    ped_req_n = 1'b1;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (phase !== 3'd0 && n < 600);
    checks++;
    if (phase !== 3'd0) begin errors++; $display("FAIL random_recover: phase %0d, required 0", phase); end
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_ped_green();
    test_ped_yellow();
    test_night();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
